// File: rtl/fir_decim_out.sv
// Integrate-and-dump decimator behind the FIR filter: sums DECIM samples, rounds,
// shifts and saturates to OUT_W bits, then queues results in a small output FIFO.
module fir_decim_out #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf,
  output logic                          sat,
  input  logic                          flag_clr
);

  localparam int ACC_W = IN_W + 4;
  localparam int SUM_W = ACC_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PH_W  = 5;
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(DECIM - 1);
  localparam int               RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [SUM_W-1:0] RND        = (SHIFT > 0) ? (SUM_W'(1) << RND_POS) : '0;
  localparam logic [SUM_W-1:0] OUT_MAX    = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(FIFO_DEPTH);

  logic [PH_W-1:0]  phase;
  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] rounded;
  logic             dump;
  logic             clip;
  logic [OUT_W-1:0] result;

  logic             res_valid;
  logic [OUT_W-1:0] res_data;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             drop;

  // Phase 0 restarts the sum, so the old accumulator contents are ignored there.
  always_comb begin
    sum = SUM_W'(in_data);
    if (phase != '0) begin
      sum = sum + SUM_W'(acc);
    end
    rounded = (sum + RND) >> SHIFT;
    clip    = (rounded > OUT_MAX);
    result  = clip ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];
    dump    = in_valid && (phase == LAST_PHASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      acc   <= '0;
    end else if (in_valid) begin
      acc   <= sum[ACC_W-1:0];
      phase <= dump ? '0 : phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= dump;
      if (dump) begin
        res_data <= result;
      end
    end
  end

  // A full FIFO still takes the pending result when the head leaves on the same edge.
  assign pop  = (count != '0) && out_ready;
  assign push = res_valid && ((count != FULL) || pop);
  assign drop = res_valid && !push;

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky flags: a new event on the same edge as flag_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      sat <= 1'b0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
      end else if (flag_clr) begin
        ovf <= 1'b0;
      end
      if (dump && clip) begin
        sat <= 1'b1;
      end else if (flag_clr) begin
        sat <= 1'b0;
      end
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_fir_decim_out.sv
// Self-checking bench for fir_decim_out: directed scenarios plus random traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_fir_decim_out;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int DECIM = 4;
  localparam int SHIFT = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned MAXV = (1 << OUT_W) - 1;
  localparam int unsigned RNDV = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] fifo_count;
  logic             ovf;
  logic             sat;
  logic             flag_clr;

  int tests = 0;
  int fails = 0;

  // Model: accepted samples of the current group, FIFO contents, one pending result.
  int unsigned samples[$];
  int unsigned fifo_q[$];
  bit          pend_v = 1'b0;
  int unsigned pend_d = 0;
  bit          m_ovf  = 1'b0;
  bit          m_sat  = 1'b0;

  always #5 clk = ~clk;

  fir_decim_out #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fifo_count(fifo_count),
    .ovf(ovf),
    .sat(sat),
    .flag_clr(flag_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied for that edge.
  task automatic model_step(input bit rst, input bit iv, input int unsigned d,
                            input bit rdy, input bit clr);
    bit          popped;
    bit          drop_ev;
    bit          clip_ev;
    int unsigned total;
    int unsigned r;
    if (rst) begin
      samples.delete();
      fifo_q.delete();
      pend_v = 1'b0;
      pend_d = 0;
      m_ovf  = 1'b0;
      m_sat  = 1'b0;
      return;
    end
    popped  = (fifo_q.size() != 0) && rdy;
    drop_ev = 1'b0;
    clip_ev = 1'b0;
    if (popped) void'(fifo_q.pop_front());
    if (pend_v) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(pend_d);
      else drop_ev = 1'b1;
    end
    pend_v = 1'b0;
    if (iv) begin
      samples.push_back(d);
      if (samples.size() == DECIM) begin
        total = 0;
        foreach (samples[i]) total += samples[i];
        r       = (total + RNDV) >> SHIFT;
        clip_ev = (r > MAXV);
        pend_d  = clip_ev ? MAXV : r;
        pend_v  = 1'b1;
        samples.delete();
      end
    end
    if (drop_ev) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clip_ev) m_sat = 1'b1;
    else if (clr) m_sat = 1'b0;
  endtask

  task automatic check_output();
    check("out_valid",  {31'd0, out_valid}, {31'd0, fifo_q.size() != 0});
    check("out_data",   32'(out_data), (fifo_q.size() != 0) ? fifo_q[0] : 32'd0);
    check("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
    check("ovf",        {31'd0, ovf}, {31'd0, m_ovf});
    check("sat",        {31'd0, sat}, {31'd0, m_sat});
  endtask

  // Each call compares the state left by the previous edge, then drives the next edge.
  task automatic apply_stimulus(input bit rst, input bit iv, input int unsigned d,
                                input bit rdy, input bit clr);
    @(negedge clk);
    check_output();
    reset     = rst;
    in_valid  = iv;
    in_data   = IN_W'(d);
    out_ready = rdy;
    flag_clr  = clr;
    model_step(rst, iv, d, rdy, clr);
  endtask

  task automatic idle(input bit rdy);
    apply_stimulus(1'b0, 1'b0, 0, rdy, 1'b0);
  endtask

  task automatic feed(input int unsigned d, input bit rdy);
    apply_stimulus(1'b0, 1'b1, d, rdy, 1'b0);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;

    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  32'(out_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);

    // Rounding and latency: 10+20+30+40 = 100, (100+2)>>2 = 25
    do_reset();
    feed(10, 1'b1); feed(20, 1'b1); feed(30, 1'b1); feed(40, 1'b1);
    idle(1'b1);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    idle(1'b1);
    check("rnd_valid", {31'd0, out_valid}, 32'd1);
    check("rnd_data",  32'(out_data), 32'd25);
    check("rnd_sat",   {31'd0, sat}, 32'd0);
    idle(1'b1);
    check("rnd_popped", 32'(fifo_count), 32'd0);

    // Idle gaps contribute nothing: 1+1+1+0 = 3, (3+2)>>2 = 1
    do_reset();
    feed(1, 1'b0); idle(1'b0); feed(1, 1'b0); idle(1'b0); idle(1'b0);
    feed(1, 1'b0); idle(1'b0); feed(0, 1'b0);
    idle(1'b0); idle(1'b0);
    check("gap_count", 32'(fifo_count), 32'd1);
    check("gap_data",  32'(out_data), 32'd1);

    // Saturation: 4*1020 = 4080, (4082)>>2 = 1020 clips to 255
    do_reset();
    for (int i = 0; i < 4; i++) feed(1020, 1'b1);
    idle(1'b1); idle(1'b1);
    check("sat_data", 32'(out_data), 32'd255);
    check("sat_flag", {31'd0, sat}, 32'd1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(1'b1);
    check("sat_clr", {31'd0, sat}, 32'd0);

    // Overflow: five results 1..5 with the consumer stalled; the fifth is lost
    do_reset();
    for (int v = 1; v <= 5; v++)
      for (int i = 0; i < 4; i++) feed(v, 1'b0);
    idle(1'b0); idle(1'b0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag",  {31'd0, ovf}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      idle(1'b1);
      check("ovf_drain", 32'(out_data), 32'(k));
    end
    idle(1'b0);
    check("ovf_empty", 32'(fifo_count), 32'd0);

    // Full FIFO with a pop on the push edge: no drop, new result goes last
    do_reset();
    for (int v = 1; v <= 4; v++)
      for (int i = 0; i < 4; i++) feed(v, 1'b0);
    for (int i = 0; i < 4; i++) feed(9, 1'b0);
    idle(1'b1);
    idle(1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ovf",   {31'd0, ovf}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      check("full_drain", 32'(out_data), (k == 3) ? 32'd9 : 32'(k + 2));
    end

    // Reset mid-accumulation discards the partial sum
    do_reset();
    feed(100, 1'b1); feed(100, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) feed(8, 1'b1);
    idle(1'b1); idle(1'b1);
    check("mid_rst_data",  32'(out_data), 32'd8);
    check("mid_rst_count", 32'(fifo_count), 32'd1);
    check("mid_rst_flags", {30'd0, ovf, sat}, 32'd0);
    idle(1'b1);
    check("mid_rst_empty", 32'(fifo_count), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned d;
      d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 400) : $urandom_range(0, 65535);
      apply_stimulus($urandom_range(0, 99) == 0,
                     $urandom_range(0, 9) < 7,
                     d,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 19) == 0);
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
